// File: rtl/servo_cmd_pkg.sv
// Shared definitions for the servo command frame decoder: FSM state
// encoding, error codes, framing constants and the target clamp helper.
package servo_cmd_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      GET_X   = 2'd1,
      GET_Y   = 2'd2,
      GET_CHK = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CHK     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [7:0] SYNC_BYTE   = 8'hAA;
   localparam logic [7:0] POS_DEFAULT = 8'd192;

   // Limit a decoded position to the [lo, hi] window of the servo stage.
   function automatic logic [7:0] clamp_pos(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
      logic [7:0] r;
      r = v;
      if (v < lo)
         r = lo;
      else if (v > hi)
         r = hi;
      return r;
   endfunction

endpackage

// File: rtl/servo_cmd_frame_decoder_byte_gap_timer.sv
// byte_gap_timer: counts idle cycles between bytes of a frame and emits a
// one-cycle expired pulse when the gap reaches TIMEOUT_CYCLES. A clear in
// the same cycle suppresses the pulse, so an arriving byte always wins.
module byte_gap_timer #(
   parameter int TIMEOUT_CYCLES = 156250
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] r_cnt;
   logic          w_at_limit;

   assign w_at_limit = (r_cnt == LIMIT);
   assign o_expired  = i_enable && !i_clear && w_at_limit;

   // Gap counter: held at zero while disabled or cleared, restarts after expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clear || !i_enable || w_at_limit)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/servo_cmd_frame_decoder.sv
// servo_cmd_frame_decoder: parses SYNC,X,Y,CHK frames from the UART byte
// stream and updates the X/Y servo targets only on checksum-valid frames.
// Optional macro FRAME_STATS_EN adds saturating good/bad frame counters.
module servo_cmd_frame_decoder
   import servo_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = servo_cmd_pkg::SYNC_BYTE,
   parameter logic [7:0] POS_DEFAULT    = servo_cmd_pkg::POS_DEFAULT,
   parameter logic [7:0] POS_MIN        = 8'd0,
   parameter logic [7:0] POS_MAX        = 8'd255,
   parameter int         TIMEOUT_CYCLES = 156250
) (
   input  logic       clk50mhz,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] x_target,
   output logic [7:0] y_target,
   output logic       cmd_valid,
   output logic       frame_err,
`ifdef FRAME_STATS_EN
   output logic [1:0] err_code,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
`else
   output logic [1:0] err_code
`endif
);

   state_t     r_state;
   logic [7:0] r_raw_x;
   logic [7:0] r_raw_y;
   logic       w_timer_en;
   logic       w_expired;
   logic [7:0] w_sum;

   // The timer only watches gaps inside a frame; HUNT waits indefinitely.
   assign w_timer_en = (r_state != HUNT);
   // Checksum covers the raw bytes, before any clamping.
   assign w_sum      = SYNC_BYTE + r_raw_x + r_raw_y;

   byte_gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk      (clk50mhz),
      .rst      (rst),
      .i_clear  (rx_valid),
      .i_enable (w_timer_en),
      .o_expired(w_expired)
   );

   // Frame FSM with registered targets, pulses and error code.
   always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) begin
         r_state   <= HUNT;
         r_raw_x   <= '0;
         r_raw_y   <= '0;
         x_target  <= POS_DEFAULT;
         y_target  <= POS_DEFAULT;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         if (rx_valid) begin
            case (r_state)
               HUNT: begin
                  if (rx_data == SYNC_BYTE)
                     r_state <= GET_X;
               end
               GET_X: begin
                  // A byte equal to SYNC here is data, not a resync.
                  r_raw_x <= rx_data;
                  r_state <= GET_Y;
               end
               GET_Y: begin
                  r_raw_y <= rx_data;
                  r_state <= GET_CHK;
               end
               GET_CHK: begin
                  if (rx_data == w_sum) begin
                     x_target  <= clamp_pos(r_raw_x, POS_MIN, POS_MAX);
                     y_target  <= clamp_pos(r_raw_y, POS_MIN, POS_MAX);
                     cmd_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_CHK;
                  end
                  r_state <= HUNT;
               end
               default: r_state <= HUNT;
            endcase
         end else if (w_expired) begin
            // Partial frame abandoned; bytes already latched are ignored.
            r_state   <= HUNT;
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
         end
      end
   end

`ifdef FRAME_STATS_EN
   // Saturating frame statistics, driven from the registered pulses.
   always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         if (cmd_valid && good_cnt != 16'hFFFF)
            good_cnt <= good_cnt + 16'd1;
         if (frame_err && bad_cnt != 16'hFFFF)
            bad_cnt <= bad_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_servo_cmd_frame_decoder.sv
// Directed bench for servo_cmd_frame_decoder: one default-window instance
// and one with a 64..200 clamp window, both fed the same byte stream.
module tb_servo_cmd_frame_decoder;

   localparam int TO = 16;

   logic       clk50mhz = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;

   logic [7:0] x_target, y_target, xc_target, yc_target;
   logic       cmd_valid, frame_err, c_cmd_valid, c_frame_err;
   logic [1:0] err_code, c_err_code;
`ifdef FRAME_STATS_EN
   logic [15:0] good_cnt, bad_cnt, c_good_cnt, c_bad_cnt;
`endif

   int n_chk = 0;
   int n_bad = 0;
   int n_cmd = 0;
   int n_err = 0;
   int n_both = 0;

   always #10 clk50mhz = ~clk50mhz;

   servo_cmd_frame_decoder #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk50mhz (clk50mhz),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .x_target (x_target),
      .y_target (y_target),
      .cmd_valid(cmd_valid),
      .frame_err(frame_err),
`ifdef FRAME_STATS_EN
      .err_code (err_code),
      .good_cnt (good_cnt),
      .bad_cnt  (bad_cnt)
`else
      .err_code (err_code)
`endif
   );

   servo_cmd_frame_decoder #(
      .POS_MIN       (8'd64),
      .POS_MAX       (8'd200),
      .TIMEOUT_CYCLES(TO)
   ) dut_c (
      .clk50mhz (clk50mhz),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .x_target (xc_target),
      .y_target (yc_target),
      .cmd_valid(c_cmd_valid),
      .frame_err(c_frame_err),
`ifdef FRAME_STATS_EN
      .err_code (c_err_code),
      .good_cnt (c_good_cnt),
      .bad_cnt  (c_bad_cnt)
`else
      .err_code (c_err_code)
`endif
   );

   // Pulse monitor on the main instance, sampled mid-cycle.
   always @(negedge clk50mhz) begin
      if (cmd_valid) n_cmd++;
      if (frame_err) n_err++;
      if (cmd_valid && frame_err) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // One byte per call; consecutive calls give rx_valid every cycle.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk50mhz);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
      send_byte(8'hAA);
      send_byte(x);
      send_byte(y);
      send_byte(c);
   endtask

   int e0;
   int wait_n;
   logic seen;

   initial begin
      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk50mhz);
      rst = 1'b0;
      @(negedge clk50mhz);

      // Reset state
      chk("rst_x", x_target, 8'hC0);
      chk("rst_y", y_target, 8'hC0);
      chk("rst_cmd", cmd_valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_code", err_code, 2'b00);
      chk("rst_xc", xc_target, 8'hC0);

      // Good frame, 1-cycle latency
      send_frame(8'h10, 8'h20, 8'hDA);
      chk("f1_cmd", cmd_valid, 1'b1);
      chk("f1_ferr", frame_err, 1'b0);
      chk("f1_x", x_target, 8'h10);
      chk("f1_y", y_target, 8'h20);
      @(negedge clk50mhz);
      chk("f1_cmd_pulse", cmd_valid, 1'b0);

      // Bad checksum, then a good frame back-to-back
      send_frame(8'h10, 8'h20, 8'h00);
      chk("f2_ferr", frame_err, 1'b1);
      chk("f2_code", err_code, 2'b01);
      chk("f2_cmd", cmd_valid, 1'b0);
      chk("f2_x", x_target, 8'h10);
      chk("f2_y", y_target, 8'h20);
      send_frame(8'h30, 8'h40, 8'h1A);
      chk("f3_cmd", cmd_valid, 1'b1);
      chk("f3_x", x_target, 8'h30);
      chk("f3_y", y_target, 8'h40);
      chk("f3_code_hold", err_code, 2'b01);

      // Gap timeout after AA,55
      send_byte(8'hAA);
      send_byte(8'h55);
      seen = 1'b0;
      wait_n = 0;
      while (!seen && wait_n < 200) begin
         @(negedge clk50mhz);
         wait_n++;
         if (frame_err) seen = 1'b1;
      end
      chk("to_seen", seen, 1'b1);
      chk("to_latency_ok", (wait_n >= TO && wait_n <= TO + 2), 1'b1);
      chk("to_code", err_code, 2'b10);
      chk("to_x", x_target, 8'h30);
      @(negedge clk50mhz);
      send_frame(8'h01, 8'h02, 8'hAD);
      chk("f4_cmd", cmd_valid, 1'b1);
      chk("f4_x", x_target, 8'h01);
      chk("f4_y", y_target, 8'h02);

      // Garbage before sync, X=AA as data
      e0 = n_err;
      send_byte(8'h12);
      send_byte(8'h34);
      send_frame(8'hAA, 8'hAA, 8'hFE);
      chk("f5_cmd", cmd_valid, 1'b1);
      chk("f5_no_err", n_err - e0, 0);
      chk("f5_x", x_target, 8'hAA);
      chk("f5_y", y_target, 8'hAA);

      // Clamp window 64..200 on the second instance
      send_frame(8'h05, 8'hFA, 8'hA9);
      chk("f6_xc", xc_target, 8'd64);
      chk("f6_yc", yc_target, 8'd200);
      chk("f6_x_noclamp", x_target, 8'h05);
      chk("f6_y_noclamp", y_target, 8'hFA);
      @(negedge clk50mhz);

`ifdef FRAME_STATS_EN
      chk("st_good", good_cnt, 16'd5);
      chk("st_bad", bad_cnt, 16'd2);
      chk("st_good_mon", good_cnt, n_cmd);
      chk("st_bad_mon", bad_cnt, n_err);
`endif

      // Reset mid-frame
      e0 = n_err + n_cmd;
      send_byte(8'hAA);
      send_byte(8'h10);
      rst = 1'b1;
      @(negedge clk50mhz);
      rst = 1'b0;
      repeat (TO + 4) @(negedge clk50mhz);
      chk("mr_x", x_target, 8'hC0);
      chk("mr_y", y_target, 8'hC0);
      chk("mr_no_pulse", n_err + n_cmd - e0, 0);
      send_frame(8'h11, 8'h22, 8'hDD);
      chk("f7_cmd", cmd_valid, 1'b1);
      chk("f7_x", x_target, 8'h11);
      chk("f7_y", y_target, 8'h22);
      @(negedge clk50mhz);
`ifdef FRAME_STATS_EN
      chk("st2_good", good_cnt, 16'd1);
      chk("st2_bad", bad_cnt, 16'd0);
`endif

      chk("never_both", n_both, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
